mem_rd_ctrl: RTL and testbench
==============================

MEM_RD_CTRL -- requirements
Module: mem_rd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  read-burst request valid.
REQ-006 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-007 SHALL have port req_addr  input  ADDR_W  first word address.
REQ-008 SHALL have port req_len  input  4  burst beats minus one (0..15 -> 1..16 beats).
REQ-009 SHALL have port mem_ce  output  1  synchronous SRAM read strobe.
REQ-010 SHALL have port mem_addr  output  ADDR_W  SRAM read address.
REQ-011 SHALL have port mem_rdata  input  DATA_W  SRAM data, valid exactly one cycle after mem_ce.
REQ-012 SHALL have port rsp_valid  output  1  response beat valid.
REQ-013 SHALL have port rsp_ready  input  1  beat consumed when rsp_valid && rsp_ready.
REQ-014 SHALL have port rsp_data  output  DATA_W  read data.
REQ-015 SHALL have port rsp_last  output  1  marks final beat of a burst.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, BURST, DRAIN.
REQ-018 SHALL drive req_ready high only in IDLE; request accepted in IDLE latches req_addr and req_len and moves to BURST.
REQ-019 SHALL, in BURST, assert mem_ce when (fifo_count + inflight) < 4, incrementing address and decrementing beat counter per issued beat.
REQ-020 SHALL wrap mem_addr modulo 2^ADDR_W (e.g. 1023 -> 0 for ADDR_W=10) with no error.
REQ-021 SHALL move BURST -> DRAIN on the cycle the last beat is issued; DRAIN -> IDLE when FIFO empty and inflight zero.
REQ-022 SHALL capture mem_rdata into a 4-entry response FIFO on the edge after mem_ce, tagging the final beat with last.
REQ-023 SHALL present the FIFO head on rsp_*; first rsp_valid two cycles after the accepting edge.
REQ-024 SHALL sustain one beat per cycle while rsp_ready is held high.
REQ-025 SHALL hold rsp_data/rsp_last stable while rsp_valid && !rsp_ready; no beat dropped or duplicated under any backpressure.
REQ-026 SHALL ignore req_valid outside IDLE; req_addr/req_len need not stay stable after acceptance.
REQ-027 SHALL treat req_len=0 as a single beat with rsp_last set.

Reset
REQ-028 SHALL, on rst_n low, asynchronously force state IDLE, FIFO empty, inflight 0, and outputs req_ready=0 (1 from first cycle after release), mem_ce=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_last=0, busy=0.
REQ-029 SHALL discard in-flight and buffered beats on reset mid-burst; no response follows reset release until a new request.

Configuration
REQ-030 SHALL, with MEM_RD_PARITY_EN defined, add input mem_rpar (1 bit, even parity over mem_rdata) and output rsp_err, set on beats whose parity mismatches, stored alongside data in the FIFO.
REQ-031 SHALL, without MEM_RD_PARITY_EN, omit mem_rpar and rsp_err entirely.

Structure
REQ-032 SHALL place state enum, FIFO depth constant (4) and parity function in package mem_rd_pkg.
REQ-033 SHALL implement the response buffer as sub-module mem_rd_fifo (depth 4, width DATA_W+1 or +2 with parity).

Verification
REQ-034 SHALL cover: addr=0x010, len=3, rsp_ready=1 -> mem_addr 0x010..0x013 consecutive cycles, 4 beats, rsp_last on 4th.
REQ-035 SHALL cover: addr=0x3FE, len=3 -> mem_addr 0x3FE,0x3FF,0x000,0x001.
REQ-036 SHALL cover: len=15, rsp_ready low 20 cycles -> mem_ce stops after 4 issues, all 16 beats delivered in order once ready returns.
REQ-037 SHALL cover: len=0 -> one beat, rsp_last=1, req_ready back high after DRAIN.
REQ-038 SHALL cover: rst_n low after 2nd beat of len=7 -> outputs at reset values, no further beats; new len=1 request completes normally.
REQ-039 SHALL cover (MEM_RD_PARITY_EN): flip mem_rpar on beat 2 of len=3 -> rsp_err=1 on beat 2 only.

Source files
------------

// File: rtl/mem_rd_pkg.sv
// mem_rd_pkg
//   Shared definitions for the burst read controller:
//     state_t      - controller FSM states (IDLE, BURST, DRAIN)
//     FIFO_DEPTH   - response buffer depth (4 entries)
//     even_parity  - even parity over a data word (zero-extended to PAR_MAX_W)
package mem_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned FIFO_DEPTH = 4;

    // Widest data word the parity helper accepts; narrower words are
    // zero-extended, which does not change the parity.
    localparam int unsigned PAR_MAX_W = 256;

    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mem_rd_fifo.sv
// mem_rd_fifo
//   Show-ahead response buffer, FIFO_DEPTH (4) entries of WIDTH bits.
//   Ports:
//     clk, rst_n  - clock, asynchronous active-low reset (empties the FIFO)
//     wr_en       - push wr_data (ignored when full)
//     wr_data     - entry to store
//     rd_en       - pop the head entry (ignored when empty)
//     rd_data     - head entry, forced to zero while empty
//     valid       - FIFO holds at least one entry
//     count       - number of stored entries (0..4)
module mem_rd_fifo
    import mem_rd_pkg::*;
#(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic [2:0]       count
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [2:0]  DEPTH_C = 3'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && (count != DEPTH_C);
    assign do_rd   = rd_en && (count != 3'd0);
    assign valid   = (count != 3'd0);
    // Zeroed while empty so the outputs read as zero out of reset without
    // having to reset the storage array.
    assign rd_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_rd_ctrl.sv
// mem_rd_ctrl
//   Burst read controller for a synchronous SRAM (1-cycle read latency).
//   Accepts a request (address, beats-1), issues up to 16 consecutive reads
//   with wrapping addresses, and returns the data through a 4-entry
//   response FIFO with ready/valid backpressure. Reads are only issued when
//   the FIFO is guaranteed room for them, so no beat is ever dropped.
//   Ports:
//     clk, rst_n            - clock, asynchronous active-low reset
//     req_valid/req_ready   - request handshake (ready only in IDLE)
//     req_addr, req_len     - first word address, beats minus one
//     mem_ce, mem_addr      - SRAM read strobe and address
//     mem_rdata             - SRAM data, valid the cycle after mem_ce
//     rsp_valid/rsp_ready   - response beat handshake
//     rsp_data, rsp_last    - response data, final-beat marker
//     busy                  - controller not in IDLE
//   Optional (`define MEM_RD_PARITY_EN):
//     mem_rpar              - even parity bit accompanying mem_rdata
//     rsp_err               - parity mismatch flag for the current beat
module mem_rd_ctrl
    import mem_rd_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_len,
    output logic              mem_ce,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy
`ifdef MEM_RD_PARITY_EN
    ,
    input  logic              mem_rpar,
    output logic              rsp_err
`endif
);

`ifdef MEM_RD_PARITY_EN
    localparam int unsigned ENT_W = DATA_W + 2;
`else
    localparam int unsigned ENT_W = DATA_W + 1;
`endif

    state_t           state;
    logic [3:0]       rem;         // beats still to issue after the current one
    logic             ce_last;     // current mem_ce is the final beat
    logic             vld_q;       // mem_rdata valid this cycle
    logic             vld_last;
    logic [2:0]       fifo_count;
    logic [ENT_W-1:0] wr_data;
    logic [ENT_W-1:0] rd_data;
    logic             can_issue;
    logic             drain_done;

    // Beats in flight (strobe cycle + data cycle) are counted against the
    // FIFO so every issued read is guaranteed a slot when it lands.
    assign can_issue  = (fifo_count + {2'b00, mem_ce} + {2'b00, vld_q}) < 3'd4;
    assign drain_done = (fifo_count == 3'd0) && !mem_ce && !vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            mem_ce    <= 1'b0;
            mem_addr  <= '0;
            rem       <= '0;
            ce_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mem_ce    <= 1'b0;
                    ce_last   <= 1'b0;
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        // First read goes out on the accepting edge; a
                        // single-beat request therefore has nothing left to
                        // issue and goes straight to DRAIN.
                        mem_ce    <= 1'b1;
                        mem_addr  <= req_addr;
                        rem       <= req_len;
                        ce_last   <= (req_len == 4'd0);
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= (req_len == 4'd0) ? DRAIN : BURST;
                    end
                end
                BURST: begin
                    if (can_issue) begin
                        mem_ce   <= 1'b1;
                        mem_addr <= mem_addr + ADDR_W'(1);
                        rem      <= rem - 4'd1;
                        ce_last  <= (rem == 4'd1);
                        if (rem == 4'd1) begin
                            state <= DRAIN;
                        end
                    end else begin
                        mem_ce  <= 1'b0;
                        ce_last <= 1'b0;
                    end
                end
                DRAIN: begin
                    mem_ce  <= 1'b0;
                    ce_last <= 1'b0;
                    if (drain_done) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_ce    <= 1'b0;
                    ce_last   <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= 1'b0;
            vld_last <= 1'b0;
        end else begin
            vld_q    <= mem_ce;
            vld_last <= ce_last;
        end
    end

`ifdef MEM_RD_PARITY_EN
    logic par_err;
    assign par_err = even_parity(PAR_MAX_W'(mem_rdata)) != mem_rpar;
    assign wr_data = {par_err, vld_last, mem_rdata};
    assign rsp_err = rd_data[DATA_W+1];
`else
    assign wr_data = {vld_last, mem_rdata};
`endif

    mem_rd_fifo #(
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (vld_q),
        .wr_data (wr_data),
        .rd_en   (rsp_ready),
        .rd_data (rd_data),
        .valid   (rsp_valid),
        .count   (fifo_count)
    );

    assign rsp_data = rd_data[DATA_W-1:0];
    assign rsp_last = rd_data[DATA_W];

endmodule

// File: tb/tb_mem_rd_ctrl.sv
// tb_mem_rd_ctrl
//   Directed bench for mem_rd_ctrl with a 1-cycle-latency SRAM model whose
//   word at address a reads as 32'hA500_0000 | a. Accepted response beats
//   and issued addresses are logged by a monitor and compared against
//   hand-derived sequences. Define MEM_RD_PARITY_EN to exercise parity.
module tb_mem_rd_ctrl;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr  = '0;
    logic [3:0]        req_len   = '0;
    logic              mem_ce;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic              busy;
    logic              err_obs;
`ifdef MEM_RD_PARITY_EN
    logic              mem_rpar  = 1'b0;
    logic              rsp_err;
    int                rd_idx    = 0;
    int                flip_idx  = -1;
    assign err_obs = rsp_err;
`else
    assign err_obs = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [33:0]       beat_q [$];
    logic [ADDR_W-1:0] iss_q  [$];

    always #5 clk = ~clk;

    mem_rd_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .mem_ce    (mem_ce),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .busy      (busy)
`ifdef MEM_RD_PARITY_EN
        ,
        .mem_rpar  (mem_rpar),
        .rsp_err   (rsp_err)
`endif
    );

    function automatic logic [31:0] pat(input logic [ADDR_W-1:0] a);
        return 32'hA500_0000 | {22'd0, a};
    endfunction

    // SRAM model and transaction monitor.
    always @(posedge clk) begin
        if (mem_ce) begin
            mem_rdata <= pat(mem_addr);
`ifdef MEM_RD_PARITY_EN
            mem_rpar  <= (^pat(mem_addr)) ^ (rd_idx == flip_idx);
            rd_idx    <= rd_idx + 1;
`endif
        end
        if (rst_n && mem_ce)
            iss_q.push_back(mem_addr);
        if (rst_n && rsp_valid && rsp_ready)
            beat_q.push_back({err_obs, rsp_last, rsp_data});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [ADDR_W-1:0] addr, input logic [3:0] len);
        for (int i = 0; i < 50 && !req_ready; i++) tick();
        chk("req_ready_before_req", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_len   = len;
        tick();
        // Scramble request fields after acceptance; the DUT must not care.
        req_valid = 1'b0;
        req_addr  = ~addr;
        req_len   = ~len;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && (busy || rsp_valid); i++) tick();
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic check_beats(input string tag, input int start, input logic [ADDR_W-1:0] base,
                               input int n, input int err_at);
        logic [ADDR_W-1:0] a;
        logic [33:0]       exp;
        chk({tag, "_count"}, 64'(beat_q.size() - start), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (start + i < beat_q.size()) begin
                a   = base + ADDR_W'(i);
                exp = {(i == err_at), (i == n - 1), pat(a)};
                chk($sformatf("%s_beat%0d", tag, i), 64'(beat_q[start + i]), 64'(exp));
            end
        end
    endtask

    initial begin
        int s;
        int si;
        logic [ADDR_W-1:0] wrap_exp [4];

        // ---------------- reset values ----------------
        rsp_ready = 1'b1;
        repeat (3) tick();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_mem_ce",    64'(mem_ce),    64'd0);
        chk("rst_mem_addr",  64'(mem_addr),  64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data",  64'(rsp_data),  64'd0);
        chk("rst_rsp_last",  64'(rsp_last),  64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        rst_n = 1'b1;
        tick();
        chk("req_ready_after_release", 64'(req_ready), 64'd1);

        // ---------------- addr 0x010, len 3, cycle-exact ----------------
        s = beat_q.size();
        do_req(10'h010, 4'd3);
        chk("t1_ce0",    64'(mem_ce),    64'd1);
        chk("t1_addr0",  64'(mem_addr),  64'h010);
        chk("t1_busy",   64'(busy),      64'd1);
        chk("t1_rdy_lo", 64'(req_ready), 64'd0);
        chk("t1_v0",     64'(rsp_valid), 64'd0);
        tick();
        chk("t1_addr1",  64'(mem_addr),  64'h011);
        chk("t1_v1",     64'(rsp_valid), 64'd0);
        tick();
        chk("t1_addr2",  64'(mem_addr),  64'h012);
        chk("t1_ce2",    64'(mem_ce),    64'd1);
        chk("t1_v2",     64'(rsp_valid), 64'd1);
        chk("t1_d2",     64'(rsp_data),  64'(pat(10'h010)));
        tick();
        chk("t1_addr3",  64'(mem_addr),  64'h013);
        chk("t1_ce3",    64'(mem_ce),    64'd1);
        chk("t1_d3",     64'(rsp_data),  64'(pat(10'h011)));
        tick();
        chk("t1_ce_off", 64'(mem_ce),    64'd0);
        wait_idle("t1", 50);
        check_beats("t1", s, 10'h010, 4, -1);
        chk("t1_rdy_back", 64'(req_ready), 64'd1);

        // ---------------- address wrap ----------------
        s  = beat_q.size();
        si = iss_q.size();
        wrap_exp[0] = 10'h3FE;
        wrap_exp[1] = 10'h3FF;
        wrap_exp[2] = 10'h000;
        wrap_exp[3] = 10'h001;
        do_req(10'h3FE, 4'd3);
        wait_idle("wrap", 50);
        chk("wrap_issues", 64'(iss_q.size() - si), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (si + k < iss_q.size())
                chk($sformatf("wrap_addr%0d", k), 64'(iss_q[si + k]), 64'(wrap_exp[k]));
        end
        check_beats("wrap", s, 10'h3FE, 4, -1);

        // ---------------- len 15 under 20 cycles of backpressure ----------------
        s  = beat_q.size();
        si = iss_q.size();
        rsp_ready = 1'b0;
        do_req(10'h100, 4'd15);
        // A second request held during the burst must be ignored.
        req_valid = 1'b1;
        req_addr  = 10'h2AA;
        req_len   = 4'd2;
        repeat (20) tick();
        chk("bp_issues_stalled", 64'(iss_q.size() - si), 64'd4);
        chk("bp_ce_off",        64'(mem_ce),    64'd0);
        chk("bp_valid",         64'(rsp_valid), 64'd1);
        chk("bp_hold_data",     64'(rsp_data),  64'(pat(10'h100)));
        chk("bp_hold_last",     64'(rsp_last),  64'd0);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle("bp", 200);
        chk("bp_issues_total", 64'(iss_q.size() - si), 64'd16);
        check_beats("bp", s, 10'h100, 16, -1);

        // ---------------- single beat ----------------
        s = beat_q.size();
        do_req(10'h055, 4'd0);
        wait_idle("one", 50);
        check_beats("one", s, 10'h055, 1, -1);
        chk("one_rdy_back", 64'(req_ready), 64'd1);

        // ---------------- reset mid-burst ----------------
        s = beat_q.size();
        do_req(10'h200, 4'd7);
        for (int i = 0; i < 20 && (beat_q.size() - s) < 2; i++) tick();
        chk("mid_two_beats", 64'(beat_q.size() - s), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_mem_ce",    64'(mem_ce),    64'd0);
        chk("mid_rst_mem_addr",  64'(mem_addr),  64'd0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_rsp_data",  64'(rsp_data),  64'd0);
        chk("mid_rst_rsp_last",  64'(rsp_last),  64'd0);
        chk("mid_rst_busy",      64'(busy),      64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        s  = beat_q.size();
        si = iss_q.size();
        repeat (10) tick();
        chk("post_rst_no_beats",  64'(beat_q.size() - s), 64'd0);
        chk("post_rst_no_issues", 64'(iss_q.size() - si), 64'd0);
        chk("post_rst_valid",     64'(rsp_valid), 64'd0);
        chk("post_rst_busy",      64'(busy),      64'd0);
        s = beat_q.size();
        do_req(10'h020, 4'd1);
        wait_idle("post", 50);
        check_beats("post", s, 10'h020, 2, -1);

`ifdef MEM_RD_PARITY_EN
        // ---------------- parity error on beat 2 ----------------
        s = beat_q.size();
        flip_idx = rd_idx + 1;
        do_req(10'h030, 4'd3);
        wait_idle("par", 50);
        flip_idx = -1;
        check_beats("par", s, 10'h030, 4, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
